// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Number of bits needed to count 0..value-1.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: a - b - br, producing a difference bit and a borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic br,
    output logic diff,
    output logic bo
);

    assign diff = a ^ b ^ br;
    assign bo   = (~a & b) | (~(a ^ b) & br);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor computing d = x - y - bin, LSB first, one bit per clock,
// with a start/done handshake and results that only update on completion.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   xs;
    logic [WIDTH-1:0]   ys;
    logic [WIDTH-1:0]   rs;
    logic               br;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               finish;
    logic               diff_bit;
    logic               borrow_bit;

    full_subtractor u_full_subtractor (
        .a    (xs[0]),
        .b    (ys[0]),
        .br   (br),
        .diff (diff_bit),
        .bo   (borrow_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Start is only honoured when idle or completing, so DONE can chain straight into SHIFT.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    finish     = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = SHIFT;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    // Result bits enter at the MSB so after WIDTH shifts the LSB has reached bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xs   <= '0;
            ys   <= '0;
            rs   <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            d    <= '0;
            bout <= 1'b0;
        end else if (accept) begin
            xs  <= x;
            ys  <= y;
            br  <= bin;
            rs  <= '0;
            cnt <= '0;
        end else if (state == SHIFT) begin
            xs  <= xs >> 1;
            ys  <= ys >> 1;
            br  <= borrow_bit;
            rs  <= {diff_bit, rs[WIDTH-1:1]};
            cnt <= cnt + CNT_W'(1);
            if (finish) begin
                d    <= {diff_bit, rs[WIDTH-1:1]};
                bout <= borrow_bit;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases, handshake corners and
// randomized operands against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         bin;
    logic [W-1:0] d;
    logic         bout;
    logic         busy;
    logic         done;

    int checks;
    int errors;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .y     (y),
        .bin   (bin),
        .d     (d),
        .bout  (bout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then sample just after it; busy and done must never overlap.
    task automatic stepCycle();
        @(posedge clk);
        #1;
        checkOutput("busy_done_exclusive", 32'(busy & done), 32'd0);
    endtask

    // Reference model: plain integer subtraction of the operands.
    function automatic logic [W-1:0] refDiff(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic bv);
        int diff;
        diff = int'(xv) - int'(yv) - int'(bv);
        return diff[W-1:0];
    endfunction

    function automatic logic refBorrow(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic bv);
        return (int'(xv) < int'(yv) + int'(bv));
    endfunction

    // Launches one operation, scrambles the inputs after acceptance and checks latency and result.
    task automatic applyStimulus(input string tag, input logic [W-1:0] xv, input logic [W-1:0] yv, input logic bv);
        logic [W-1:0] hold_d;
        logic         hold_b;
        int           edges;
        int           guard;
        guard = 0;
        while (busy && guard < 4 * W) begin
            stepCycle();
            guard++;
        end
        start = 1'b1;
        x     = xv;
        y     = yv;
        bin   = bv;
        stepCycle();
        start  = 1'b0;
        x      = W'($urandom);
        y      = W'($urandom);
        bin    = 1'($urandom);
        hold_d = d;
        hold_b = bout;
        edges  = 0;
        while (!done && edges < 3 * W) begin
            checkOutput({tag, "_hold"}, {27'd0, hold_b, hold_d}, {27'd0, bout, d});
            stepCycle();
            edges++;
        end
        checkOutput({tag, "_latency"}, 32'(edges), 32'(W));
        checkOutput({tag, "_d"}, 32'(d), 32'(refDiff(xv, yv, bv)));
        checkOutput({tag, "_bout"}, 32'(bout), 32'(refBorrow(xv, yv, bv)));
    endtask

    initial begin
        int edges;
        int activity;
        checks = 0;
        errors = 0;
        start  = 1'b0;
        x      = '0;
        y      = '0;
        bin    = 1'b0;
        rst_n  = 1'b0;
        #2;
        checkOutput("reset_d", 32'(d), 32'd0);
        checkOutput("reset_bout", 32'(bout), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        #10;
        rst_n = 1'b1;
        stepCycle();

        applyStimulus("basic1", 4'b1010, 4'b0101, 1'b0);
        applyStimulus("basic2", 4'b1101, 4'b1000, 1'b1);
        applyStimulus("under1", 4'b0100, 4'b1100, 1'b0);
        applyStimulus("under2", 4'b0010, 4'b1010, 1'b1);
        stepCycle();

        // Reset in the middle of an operation after a nonzero result is on d.
        start = 1'b1;
        x     = 4'b1010;
        y     = 4'b0101;
        bin   = 1'b0;
        stepCycle();
        start = 1'b0;
        stepCycle();
        stepCycle();
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_d", 32'(d), 32'd0);
        checkOutput("midreset_bout", 32'(bout), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_done", 32'(done), 32'd0);
        #3;
        rst_n    = 1'b1;
        activity = 0;
        for (int i = 0; i < 8; i++) begin
            stepCycle();
            activity += int'(busy) + int'(done);
        end
        checkOutput("midreset_no_resume", 32'(activity), 32'd0);

        // Back-to-back with start held high throughout.
        start = 1'b1;
        x     = 4'b1111;
        y     = 4'b1110;
        bin   = 1'b0;
        stepCycle();
        x     = 4'b0110;
        y     = 4'b1010;
        bin   = 1'b1;
        edges = 0;
        while (!done && edges < 20) begin
            stepCycle();
            edges++;
        end
        checkOutput("b2b_latency", 32'(edges), 32'd4);
        checkOutput("b2b_d1", 32'(d), 32'b0001);
        checkOutput("b2b_bout1", 32'(bout), 32'd0);
        stepCycle();
        edges = 1;
        while (!done && edges < 20) begin
            stepCycle();
            edges++;
        end
        checkOutput("b2b_spacing", 32'(edges), 32'd5);
        checkOutput("b2b_d2", 32'(d), 32'b1011);
        checkOutput("b2b_bout2", 32'(bout), 32'd1);
        start = 1'b0;
        stepCycle();
        checkOutput("b2b_idle", {30'd0, busy, done}, 32'd0);

        // A start pulse during SHIFT must be dropped.
        start = 1'b1;
        x     = 4'b1101;
        y     = 4'b1101;
        bin   = 1'b1;
        stepCycle();
        start = 1'b0;
        stepCycle();
        start = 1'b1;
        x     = 4'b1000;
        y     = 4'b0110;
        bin   = 1'b1;
        stepCycle();
        start = 1'b0;
        edges = 2;
        while (!done && edges < 20) begin
            stepCycle();
            edges++;
        end
        checkOutput("ignored_latency", 32'(edges), 32'd4);
        checkOutput("ignored_d", 32'(d), 32'b1111);
        checkOutput("ignored_bout", 32'(bout), 32'd1);
        activity = 0;
        for (int i = 0; i < 8; i++) begin
            stepCycle();
            activity += int'(busy) + int'(done);
        end
        checkOutput("ignored_no_extra", 32'(activity), 32'd0);

        for (int i = 0; i < 512; i++) begin
            applyStimulus("random", W'($urandom), W'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                stepCycle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
